// File: rtl/master_control_if.sv
// master_control_if: user request, data and slave handshake bundle for master_control
interface master_control_if;
  logic send;
  logic [2:0] data_in;
  logic ack;
  logic request;
  logic [2:0] data_out;
  logic valid;
  logic notice;
  logic error;
  modport master(input send, data_in, ack, output request, data_out, valid, notice, error);
  modport slave(output send, data_in, ack, input request, data_out, valid, notice, error);
endinterface

// File: rtl/master_control.sv
// master_control: four-phase request/ack master with timeouts, notice LED and sticky error
module master_control #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int NOTICE_CYCLES = 100_000_000
) (
  input logic clk,
  input logic rst,
  master_control_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND_DATA, DONE} state_t;
  localparam logic [26:0] to_last = 27'(TIMEOUT_CYCLES - 1);
  localparam logic [26:0] nt_last = 27'(NOTICE_CYCLES - 1);
  state_t state, state_n;
  logic [26:0] cnt;
  logic ack_m, ack_s, timed_out;
  logic request_n, valid_n, notice_n, error_n;
  logic [2:0] data_n;
  // two-flop synchronizer for the slave's asynchronous ack
  always_ff @(posedge clk) begin
    ack_m <= rst ? 1'b0 : bus.ack;
    ack_s <= rst ? 1'b0 : ack_m;
  end
  // state, saturating dwell counter (cleared on every state entry) and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.request <= 1'b0;
      bus.valid <= 1'b0;
      bus.notice <= 1'b0;
      bus.error <= 1'b0;
      bus.data_out <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : &cnt ? cnt : cnt + 27'd1;
      bus.request <= request_n;
      bus.valid <= valid_n;
      bus.notice <= notice_n;
      bus.error <= error_n;
      bus.data_out <= data_n;
    end
  end
  // next state: ack-driven moves take priority over timeouts
  always_comb begin
    state_n = state;
    timed_out = 1'b0;
    case (state)
      IDLE: state_n = bus.send ? WAIT_ACK : IDLE;
      WAIT_ACK: begin
        timed_out = !ack_s && cnt == to_last;
        state_n = ack_s ? SEND_DATA : timed_out ? IDLE : WAIT_ACK;
      end
      SEND_DATA: begin
        timed_out = ack_s && cnt == to_last;
        state_n = !ack_s ? DONE : timed_out ? IDLE : SEND_DATA;
      end
      DONE: state_n = cnt == nt_last ? IDLE : DONE;
    endcase
  end
  // next register values for outputs, derived from the state being entered
  always_comb begin
    request_n = state_n == WAIT_ACK;
    valid_n = state_n == SEND_DATA;
    notice_n = state_n != IDLE;
    error_n = timed_out | (bus.error & !(state == IDLE && bus.send));
    data_n = state == IDLE && bus.send ? bus.data_in : bus.data_out;
  end
endmodule

// File: tb/tb_master_control.sv
// tb_master_control: directed and random transfers checked against an interval-level model
module tb_master_control;
  localparam int T = 20, N = 8, NE = 3000;
  logic clk = 1'b0;
  logic rst;
  master_control_if bus();
  master_control #(.TIMEOUT_CYCLES(T), .NOTICE_CYCLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic s_rst[NE], s_send[NE], s_ack[NE];
  logic [2:0] s_din[NE];
  logic [6:0] exp_out[NE];
  int total = 0, bad = 0, edge_no = 0;
  logic err_m;
  logic [2:0] dout_m;
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", tag, edge_no, got, want);
    end
  endtask
  // ack value the controller acts on at edge e: two flops of delay, flushed by reset
  function automatic logic seen(input int e);
    if (e < 2) return 1'b0;
    return (s_rst[e-1] || s_rst[e-2]) ? 1'b0 : s_ack[e-2];
  endfunction
  task automatic put(input int i, input logic r, input logic v, input logic n);
    exp_out[i] = {r, v, n, err_m, dout_m};
  endtask
  // one phase entered at edge k; how: 0 reset, 1 ack condition met, 2 limit reached, 3 ran off end
  task automatic phase(input int k, input int lim, input int want, input logic r, input logic v,
                       input logic n, output int x, output int how);
    x = NE;
    how = 3;
    for (int j = 1; j <= lim; j++) begin
      if (k + j >= NE) break;
      if (s_rst[k+j]) begin x = k + j; how = 0; break; end
      if (want >= 0 && seen(k + j) == 1'(want)) begin x = k + j; how = 1; break; end
      if (j == lim) begin x = k + j; how = 2; end
    end
    for (int i = k; i < x; i++) put(i, r, v, n);
  endtask
  task automatic build_model;
    int e, x, how;
    e = 0;
    err_m = 1'b0;
    dout_m = 3'd0;
    while (e < NE) begin
      if (s_rst[e]) begin
        err_m = 1'b0;
        dout_m = 3'd0;
        put(e, 0, 0, 0);
        e++;
      end else if (!s_send[e]) begin
        put(e, 0, 0, 0);
        e++;
      end else begin
        err_m = 1'b0;
        dout_m = s_din[e];
        phase(e, T, 1, 1, 0, 1, x, how);
        if (how == 1) phase(x, T, 0, 0, 1, 1, x, how);
        if (how == 1) begin
          phase(x, N, -1, 0, 0, 1, x, how);
          if (how == 2) how = 4;
        end
        if (how == 2) err_m = 1'b1;
        if (how == 2 || how == 4) begin
          if (x < NE) put(x, 0, 0, 0);
          e = x + 1;
        end else e = x;
      end
    end
  endtask
  task automatic xfer(input int p, input logic [2:0] d, input int rise, input int hold);
    s_send[p] = 1'b1;
    s_din[p] = d;
    for (int i = p + rise; i < p + rise + hold && i < NE; i++) s_ack[i] = 1'b1;
  endtask
  initial begin
    int p;
    for (int i = 0; i < NE; i++) begin
      s_rst[i] = 1'b0;
      s_send[i] = 1'b0;
      s_ack[i] = 1'b0;
      s_din[i] = 3'($urandom);
    end
    for (int i = 0; i < 3; i++) s_rst[i] = 1'b1;
    p = 4;
    xfer(p, 5, 4, 5); p += 60;
    xfer(p, 3, 0, 0); p += 30;
    xfer(p, 6, 4, 5); p += 60;
    xfer(p, 7, 3, 45); p += 70;
    xfer(p, 5, 6, 5);
    s_send[p+2] = 1'b1;
    for (int i = p + 1; i < p + 20; i++) s_din[i] = 3'd2;
    p += 60;
    xfer(p, 4, 2, 30);
    s_rst[p+8] = 1'b1;
    p += 60;
    for (int i = p; i < p + 4; i++) s_ack[i] = 1'b1;
    p += 20;
    xfer(p, 1, 18, 5); p += 70;
    while (p < NE - 140) begin
      xfer(p, 3'($urandom), $urandom_range(0, 26), $urandom_range(1, 26));
      if ($urandom % 4 == 0) s_send[p + $urandom_range(1, 30)] = 1'b1;
      if ($urandom % 6 == 0) s_rst[p + $urandom_range(1, 45)] = 1'b1;
      if ($urandom % 5 == 0) for (int i = p + 56; i < p + 59; i++) s_ack[i] = 1'b1;
      p += 64;
    end
    build_model();
    rst = 1'b1;
    bus.send = 1'b0;
    bus.data_in = 3'd0;
    bus.ack = 1'b0;
    for (int e = 0; e < NE; e++) begin
      @(negedge clk);
      rst = s_rst[e];
      bus.send = s_send[e];
      bus.data_in = s_din[e];
      bus.ack = s_ack[e];
      @(posedge clk);
      #1;
      edge_no = e;
      chk("out", {bus.request, bus.valid, bus.notice, bus.error, bus.data_out}, exp_out[e]);
      chk("excl", {6'd0, bus.request & bus.valid}, 7'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
